// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the uart_tx byte arbiter: FSM state encoding,
// parameter defaults and byte width.
package uart_tx_arb_pkg;

    // Arbiter FSM states. Encoding is fixed so the debug port reads the same
    // values in every build.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

    // Default number of requesters sharing one uart_tx.
    localparam int NREQ_DEFAULT    = 4;

    // Default cycles to wait for tx_busy to rise after a start pulse.
    localparam int BUSY_TO_DEFAULT = 4;

    // Width of one requester byte lane.
    localparam int BYTE_W          = 8;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Round-robin priority pick: returns a one-hot winner, searching upward from
// ptr_i and wrapping to bit 0. An empty request vector gives an all-zero grant.
module uart_tx_arb_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o
);

    logic [NREQ-1:0] upper;
    logic [NREQ-1:0] cand;
    logic            found;

    // Requests at or above the pointer take priority; fall back to the full
    // vector when none are set there (this is the wrap-around case).
    always_comb begin
        upper = '0;
        for (int i = 0; i < NREQ; i++) begin
            upper[i] = req_i[i] & (i >= int'(ptr_i));
        end
        cand = (|upper) ? upper : req_i;
    end

    // Lowest set bit of the candidate vector wins.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && cand[i]) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Byte arbiter in front of a single uart_tx. Several requesters offer bytes
// with valid/ready; a burst (bytes up to req_last) keeps the transmitter
// locked to one requester. Each accepted byte is launched with a one-cycle
// tx_en pulse, and the arbiter then waits for tx_busy to rise and fall
// before accepting the next byte.
//
// Handshake: a byte moves from requester i when req_valid[i] & req_ready[i]
// are both high at a rising clk edge. req_ready is combinational from
// req_valid, is raised only in IDLE, and only for the single winner.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEFAULT,
    parameter int BUSY_TO = BUSY_TO_DEFAULT
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [BYTE_W*NREQ-1:0]     req_data,
    input  logic [NREQ-1:0]            req_last,
    output logic [NREQ-1:0]            req_ready,
    output logic                       tx_en,
    output logic [BYTE_W-1:0]          tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       locked,
    output logic                       active,
    output logic [1:0]                 dbg_state
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(BUSY_TO + 1);

    // Registered state.
    arb_state_e        state_q;
    logic              tx_en_q;
    logic [BYTE_W-1:0] tx_data_q;
    logic [GW-1:0]     grant_id_q;
    logic              locked_q;
    logic [GW-1:0]     rr_ptr_q;
    logic [CW-1:0]     to_cnt_q;

    // Combinational arbitration results.
    logic [NREQ-1:0]   owner_mask;
    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   win_oh;
    logic [GW-1:0]     win_idx_d;
    logic [BYTE_W-1:0] win_byte_d;
    logic              win_last_d;
    logic [GW-1:0]     rr_ptr_d;
    logic              xfer;

    // While a burst lock is held only the owner (grant_id_q) may compete.
    always_comb begin
        owner_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            owner_mask[i] = (grant_id_q == GW'(i));
        end
        eligible = locked_q ? (req_valid & owner_mask) : req_valid;
    end

    uart_tx_arb_rr_pick #(
        .NREQ (NREQ),
        .PW   (GW)
    ) u_rr_pick (
        .req_i   (eligible),
        .ptr_i   (rr_ptr_q),
        .grant_o (win_oh)
    );

    // Decode the one-hot winner into its index, byte and last flag.
    always_comb begin
        win_idx_d  = '0;
        win_byte_d = '0;
        win_last_d = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                win_idx_d  = GW'(i);
                win_byte_d = req_data[BYTE_W*i +: BYTE_W];
                win_last_d = req_last[i];
            end
        end
    end

    // Next round-robin pointer: one past the winner, wrapping at NREQ-1.
    always_comb begin
        if (win_idx_d == GW'(NREQ - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = win_idx_d + GW'(1);
        end
    end

    // Ready is forced low during reset so nothing is accepted while resetn=0.
    assign xfer      = (state_q == ST_IDLE) && (|win_oh);
    assign req_ready = (resetn && (state_q == ST_IDLE)) ? win_oh : '0;

    // Arbiter FSM with its registered outputs, lock and round-robin pointer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            tx_en_q    <= 1'b0;
            tx_data_q  <= '0;
            grant_id_q <= '0;
            locked_q   <= 1'b0;
            rr_ptr_q   <= '0;
            to_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        tx_data_q  <= win_byte_d;
                        grant_id_q <= win_idx_d;
                        tx_en_q    <= 1'b1;
                        state_q    <= ST_ISSUE;
                        // A non-last byte opens (or keeps) the lock; the
                        // owner's last byte closes it.
                        locked_q   <= !win_last_d;
                        if (!locked_q || win_last_d) begin
                            rr_ptr_q <= rr_ptr_d;
                        end
                    end
                end
                ST_ISSUE: begin
                    tx_en_q  <= 1'b0;
                    to_cnt_q <= '0;
                    state_q  <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (to_cnt_q == CW'(BUSY_TO - 1)) begin
                        // uart_tx never acknowledged; treat the byte as sent.
                        state_q <= ST_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + CW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    tx_en_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_en     = tx_en_q;
    assign tx_data   = tx_data_q;
    assign grant_id  = grant_id_q;
    assign locked    = locked_q;
    assign active    = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb (NREQ=4, BUSY_TO=4): a cycle table of directed
// vectors, then hand-written sequences for timeout, fairness and reset
// during a locked burst. Every tx_en pulse is also matched against an
// expected {grant_id, tx_data} queue.
module tb_uart_tx_arb;
  import uart_tx_arb_pkg::*;

  localparam logic [31:0] D0 = 32'hD3C2B1A0;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = D0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        locked;
  logic        active;
  logic [1:0]  dbg_state;

  logic        tb_busy = 1'b0;
  logic        model_on = 1'b0;
  logic [2:0]  model_cnt = '0;

  int total = 0;
  int bad = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_exp;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        busy;
    logic [3:0]  exp_ready;
    logic        exp_en;
    logic [7:0]  exp_data;
    logic [1:0]  exp_gid;
    logic        exp_lock;
    logic        exp_act;
  } vec_t;

  vec_t vecs[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  assign tx_busy = model_on ? (model_cnt != 3'd0) : tb_busy;

  // simple uart_tx stand-in: busy for 3 cycles after each start pulse
  always @(posedge clk) begin
    if (tx_en) model_cnt <= 3'd3;
    else if (model_cnt != 3'd0) model_cnt <= model_cnt - 3'd1;
  end

  uart_tx_arb #(
    .NREQ    (4),
    .BUSY_TO (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .locked    (locked),
    .active    (active),
    .dbg_state (dbg_state)
  );

  // scoreboard: every start pulse must match the next expected byte
  always @(negedge clk) begin
    if (resetn && tx_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got gid=%0d data=%h, required no byte", grant_id, tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({grant_id, tx_data} !== mon_exp) begin
          bad++;
          $display("FAIL sb_byte: got gid=%0d data=%h, required gid=%0d data=%h",
                   grant_id, tx_data, mon_exp[9:8], mon_exp[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic add_v(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                       input logic b, input logic [3:0] r, input logic e,
                       input logic [7:0] td, input logic [1:0] g, input logic lk,
                       input logic ac);
    vec_t x;
    x.valid = v; x.last = l; x.data = d; x.busy = b;
    x.exp_ready = r; x.exp_en = e; x.exp_data = td; x.exp_gid = g;
    x.exp_lock = lk; x.exp_act = ac;
    vecs.push_back(x);
    if (e) exp_q.push_back({g, td});
  endtask

  task automatic chk_outputs(input string tag, input logic [3:0] r, input logic e,
                             input logic [7:0] td, input logic [1:0] g,
                             input logic lk, input logic ac);
    chk({tag, ".ready"}, 32'(req_ready), 32'(r));
    chk({tag, ".tx_en"}, 32'(tx_en), 32'(e));
    chk({tag, ".tx_data"}, 32'(tx_data), 32'(td));
    chk({tag, ".grant_id"}, 32'(grant_id), 32'(g));
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
    chk({tag, ".active"}, 32'(active), 32'(ac));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk); #4;
      n++;
    end while (active && n < budget);
    total++;
    if (active) begin
      bad++;
      $display("FAIL %s: active still 1 after %0d cycles, required 0", name, budget);
    end
  endtask

  initial begin
    // 2 requesters (0,2), single-byte each: 0 first then 2; then idle hold
    add_v(4'b0101, 4'b1111, D0, 0, 4'b0001, 0, 8'h00, 0, 0, 0);
    add_v(4'b0100, 4'b1111, D0, 0, 4'b0000, 1, 8'hA0, 0, 0, 1);
    add_v(4'b0100, 4'b1111, D0, 1, 4'b0000, 0, 8'hA0, 0, 0, 1);
    add_v(4'b0100, 4'b1111, D0, 1, 4'b0000, 0, 8'hA0, 0, 0, 1);
    add_v(4'b0100, 4'b1111, D0, 0, 4'b0000, 0, 8'hA0, 0, 0, 1);
    add_v(4'b0100, 4'b1111, D0, 0, 4'b0100, 0, 8'hA0, 0, 0, 0);
    add_v(4'b0000, 4'b1111, D0, 0, 4'b0000, 1, 8'hC2, 2, 0, 1);
    add_v(4'b0000, 4'b1111, D0, 1, 4'b0000, 0, 8'hC2, 2, 0, 1);
    add_v(4'b0000, 4'b1111, D0, 0, 4'b0000, 0, 8'hC2, 2, 0, 1);
    add_v(4'b0000, 4'b1111, D0, 0, 4'b0000, 0, 8'hC2, 2, 0, 0);
    add_v(4'b0000, 4'b1111, D0, 0, 4'b0000, 0, 8'hC2, 2, 0, 0);
    // requester 1 burst 41,42,43 while requester 3 waits (rr_ptr=3 here)
    add_v(4'b0010, 4'b1101, 32'hD3C241A0, 0, 4'b0010, 0, 8'hC2, 2, 0, 0);
    add_v(4'b1010, 4'b1101, 32'hD3C242A0, 0, 4'b0000, 1, 8'h41, 1, 1, 1);
    add_v(4'b1010, 4'b1101, 32'hD3C242A0, 1, 4'b0000, 0, 8'h41, 1, 1, 1);
    add_v(4'b1010, 4'b1101, 32'hD3C242A0, 0, 4'b0000, 0, 8'h41, 1, 1, 1);
    add_v(4'b1000, 4'b1101, 32'hD3C242A0, 0, 4'b0000, 0, 8'h41, 1, 1, 0);
    add_v(4'b1000, 4'b1101, 32'hD3C242A0, 0, 4'b0000, 0, 8'h41, 1, 1, 0);
    add_v(4'b1010, 4'b1101, 32'hD3C242A0, 0, 4'b0010, 0, 8'h41, 1, 1, 0);
    add_v(4'b1010, 4'b1111, 32'hD3C243A0, 0, 4'b0000, 1, 8'h42, 1, 1, 1);
    add_v(4'b1010, 4'b1111, 32'hD3C243A0, 1, 4'b0000, 0, 8'h42, 1, 1, 1);
    add_v(4'b1010, 4'b1111, 32'hD3C243A0, 0, 4'b0000, 0, 8'h42, 1, 1, 1);
    add_v(4'b1010, 4'b1111, 32'hD3C243A0, 0, 4'b0010, 0, 8'h42, 1, 1, 0);
    add_v(4'b1000, 4'b1111, D0, 0, 4'b0000, 1, 8'h43, 1, 0, 1);
    add_v(4'b1000, 4'b1111, D0, 1, 4'b0000, 0, 8'h43, 1, 0, 1);
    add_v(4'b1000, 4'b1111, D0, 0, 4'b0000, 0, 8'h43, 1, 0, 1);
    add_v(4'b1000, 4'b1111, D0, 0, 4'b1000, 0, 8'h43, 1, 0, 0);
    add_v(4'b0000, 4'b1111, D0, 0, 4'b0000, 1, 8'hD3, 3, 0, 1);
    add_v(4'b0000, 4'b1111, D0, 1, 4'b0000, 0, 8'hD3, 3, 0, 1);
    add_v(4'b0000, 4'b1111, D0, 0, 4'b0000, 0, 8'hD3, 3, 0, 1);
    add_v(4'b0000, 4'b1111, D0, 0, 4'b0000, 0, 8'hD3, 3, 0, 0);

    // power-on reset values
    repeat (3) @(posedge clk);
    #4;
    chk_outputs("reset0", 4'b0000, 0, 8'h00, 0, 0, 0);
    chk("reset0.state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1 resetn = 1'b1;

    // table-driven cycles
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      req_valid = vecs[i].valid;
      req_last  = vecs[i].last;
      req_data  = vecs[i].data;
      tb_busy   = vecs[i].busy;
      #3;
      chk_outputs($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_en,
                  vecs[i].exp_data, vecs[i].exp_gid, vecs[i].exp_lock, vecs[i].exp_act);
    end

    // busy timeout: tx_busy never rises, IDLE 4 cycles after WAIT_BUSY entry
    begin
      logic [5:0] exp_act;
      logic [5:0] exp_en;
      logic [1:0] exp_st[6];
      exp_act = 6'b011111;
      exp_en  = 6'b000001;
      exp_st  = '{ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_BUSY, ST_WAIT_BUSY, ST_WAIT_BUSY, ST_IDLE};
      tb_busy = 1'b0;
      req_data = D0;
      @(posedge clk); #1;
      req_valid = 4'b0001; req_last = 4'b1111;
      #3 chk("to.ready_req", 32'(req_ready), 32'h1);
      exp_q.push_back({2'd0, 8'hA0});
      @(posedge clk); #1 req_valid = 4'b0000;
      for (int k = 0; k < 6; k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        if (k == 5) req_valid = 4'b0100;
        #3;
        chk($sformatf("to.c%0d.active", k), 32'(active), 32'(exp_act[k]));
        chk($sformatf("to.c%0d.tx_en", k), 32'(tx_en), 32'(exp_en[k]));
        chk($sformatf("to.c%0d.state", k), 32'(dbg_state), 32'(exp_st[k]));
      end
      chk("to.next_ready", 32'(req_ready), 32'h4);
      exp_q.push_back({2'd2, 8'hC2});
      @(posedge clk); #1 req_valid = 4'b0000;
      #3 chk("to.next_tx_en", 32'(tx_en), 32'h1);
      wait_idle("to.next_done", 20);
    end

    // reset with requesters valid: ready must stay 0, then fairness 0,1,2,3,0
    @(posedge clk); #1;
    req_valid = 4'b1111; req_last = 4'b1111; req_data = D0;
    #1 resetn = 1'b0;
    #1 chk_outputs("reset1", 4'b0000, 0, 8'h00, 0, 0, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    model_on = 1'b1;
    exp_q.push_back({2'd0, 8'hA0});
    exp_q.push_back({2'd1, 8'hB1});
    exp_q.push_back({2'd2, 8'hC2});
    exp_q.push_back({2'd3, 8'hD3});
    exp_q.push_back({2'd0, 8'hA0});
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(posedge clk); #4;
        n++;
      end
      req_valid = 4'b0000;
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL rr.grants: %0d grants still pending after %0d cycles, required 0", exp_q.size(), n);
        exp_q.delete();
      end
    end
    wait_idle("rr.done", 20);

    // reset during WAIT_DONE of a locked burst from requester 2
    @(posedge clk); #1;
    req_valid = 4'b0100; req_last = 4'b0000;
    #3 chk("lk.ready", 32'(req_ready), 32'h4);
    exp_q.push_back({2'd2, 8'hC2});
    @(posedge clk); #1 req_valid = 4'b0000;
    begin
      int n;
      n = 0;
      while (dbg_state != ST_WAIT_DONE && n < 20) begin
        @(posedge clk); #3;
        n++;
      end
      chk("lk.in_wait_done", 32'(dbg_state), 32'(ST_WAIT_DONE));
    end
    chk("lk.locked", 32'(locked), 32'h1);
    chk("lk.grant_id", 32'(grant_id), 32'h2);
    req_valid = 4'b0110;
    #1 resetn = 1'b0;
    #1;
    chk_outputs("lk.reset", 4'b0000, 0, 8'h00, 0, 0, 0);
    chk("lk.reset.state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    resetn = 1'b1;
    req_valid = 4'b1010; req_last = 4'b1111;
    #3 chk("lk.after_ready", 32'(req_ready), 32'h2);
    exp_q.push_back({2'd1, 8'hB1});
    @(posedge clk); #1 req_valid = 4'b0000;
    #3 chk("lk.after_tx_en", 32'(tx_en), 32'h1);
    chk("lk.after_locked", 32'(locked), 32'h0);
    wait_idle("lk.after_done", 20);

    chk("sb.drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
